adder_pipe: RTL and testbench



---
 rtl/adder_pkg.sv | 28 ++
 rtl/adder_pipe_stage.sv | 79 +++++++
 rtl/adder_pipe.sv | 72 +++++++
 tb/tb_adder_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and segmentation helpers for the carry-split adder pipeline.
// WIDTH must not exceed MAX_W; payload vectors are sized for the widest build.
package adder_pkg;

   localparam int MAX_W = 64;

   typedef struct packed {
      logic [MAX_W-1:0] res;     // result bits already produced by earlier stages
      logic [MAX_W-1:0] a;       // operand A, upper bits still pending
      logic [MAX_W-1:0] b;       // operand B (uninverted), upper bits still pending
      logic             cy;      // carry into the next segment
      logic             sub;
      logic             msb_ci;  // carry into the MSB, captured by whichever stage owns it
      logic             ovf;
   } stage_pl_t;

   function automatic int seg_width(int width, int latency);
      return (width + latency - 1) / latency;
   endfunction

   // Start bit of segment i, clamped so trailing segments may be empty.
   function automatic int seg_lo(int i, int width, int latency);
      int lo;
      lo = i * seg_width(width, latency);
      return (lo > width) ? width : lo;
   endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline stage: ripple-adds its operand segment onto the incoming carry and
// holds the payload in a valid/ready register slice. Last stage also forms ovf.
module adder_pipe_stage
   import adder_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2,
   parameter int IDX     = 0
) (
   input  logic      aclk,
   input  logic      arstn,
   input  logic      srst,
   input  logic      up_valid,
   input  stage_pl_t up_pl,
   input  logic      dn_ready,
   output logic      dn_valid,
   output stage_pl_t dn_pl
);

   localparam int LO = seg_lo(IDX, WIDTH, LATENCY);
   localparam int HI = seg_lo(IDX + 1, WIDTH, LATENCY);

   logic      v_q, v_d;
   logic      ready;
   logic      cy, bb;
   stage_pl_t pl_q, pl_d, seg_pl;

   assign ready = ~v_q | dn_ready;

   always_comb begin
      seg_pl = up_pl;
      cy     = up_pl.cy;
      bb     = 1'b0;
      for (int i = LO; i < HI; i++) begin
         bb = up_pl.b[i] ^ up_pl.sub;
         if (i == WIDTH - 1) seg_pl.msb_ci = cy;
         seg_pl.res[i] = up_pl.a[i] ^ bb ^ cy;
         cy = (up_pl.a[i] & bb) | (cy & (up_pl.a[i] ^ bb));
      end
      seg_pl.cy = cy;
      // Empty trailing segments pass cy through, so cy here is the MSB carry-out.
      if (IDX == LATENCY - 1) begin
         seg_pl.ovf = seg_pl.msb_ci ^ cy;
`ifdef ADDER_PIPE_SAT_EN
         if (seg_pl.ovf) begin
            for (int i = 0; i < WIDTH; i++)
               seg_pl.res[i] = (i == WIDTH - 1) ? up_pl.a[WIDTH-1] : ~up_pl.a[WIDTH-1];
         end
`endif
      end
   end

   always_comb begin
      v_d  = v_q;
      pl_d = pl_q;
      if (ready) begin
         v_d = up_valid;
         if (up_valid) pl_d = seg_pl;
      end
      if (srst) begin
         v_d  = 1'b0;
         pl_d = '0;
      end
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         v_q  <= 1'b0;
         pl_q <= '0;
      end else begin
         v_q  <= v_d;
         pl_q <= pl_d;
      end
   end

   assign dn_valid = v_q;
   assign dn_pl    = pl_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract with carry/ovf flags and valid/ready on both sides.
// Define ADDER_PIPE_SAT_EN to saturate the signed result on overflow.
module adder_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2
) (
   input  logic             aclk,
   input  logic             arstn,
   input  logic             srst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             carry,
   output logic             ovf
);

   logic [LATENCY:0] vld_pipe;
   logic [LATENCY:0] rdy;
   stage_pl_t        pl [LATENCY:0];
   stage_pl_t        pl_in;
   logic             unused_pl;

   always_comb begin
      pl_in                = '0;
      pl_in.a[WIDTH-1:0]   = a;
      pl_in.b[WIDTH-1:0]   = b;
      pl_in.cy             = sub;
      pl_in.sub            = sub;
   end

   assign pl[0]       = pl_in;
   assign vld_pipe[0] = in_valid;

   // Ready chain built from the registered valid bits in one place.
   always_comb begin
      rdy[LATENCY] = out_ready;
      for (int k = LATENCY - 1; k >= 0; k--)
         rdy[k] = ~vld_pipe[k+1] | rdy[k+1];
   end

   for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      adder_pipe_stage #(
         .WIDTH   (WIDTH),
         .LATENCY (LATENCY),
         .IDX     (k)
      ) u_stage (
         .aclk     (aclk),
         .arstn    (arstn),
         .srst     (srst),
         .up_valid (vld_pipe[k]),
         .up_pl    (pl[k]),
         .dn_ready (rdy[k+1]),
         .dn_valid (vld_pipe[k+1]),
         .dn_pl    (pl[k+1])
      );
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld_pipe[LATENCY];
   assign c         = pl[LATENCY].res[WIDTH-1:0];
   assign carry     = pl[LATENCY].cy;
   assign ovf       = pl[LATENCY].ovf;
   assign unused_pl = ^pl[LATENCY];

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench: three adder_pipe builds (32/4, 32/1, 8/8) against an arithmetic model.
module tb_adder_pipe;

   logic aclk = 1'b0;
   logic arstn, srst;
   always #5 aclk = ~aclk;

   logic        iv[3], ir[3], sb[3], ov[3], orr[3], cy[3], of[3];
   logic [31:0] av[3], bv[3], cv[3];
   int chk = 0, err = 0;

`ifdef ADDER_PIPE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   task automatic check(string name, logic [33:0] got, logic [33:0] exp);
      chk++;
      if (got !== exp) begin
         err++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // Returns {ovf, carry, c} from plain integer arithmetic on w-bit operands.
   function automatic logic [33:0] model(int w, logic [31:0] x, logic [31:0] y, logic s);
      longint unsigned m, ua, ub, res;
      longint sa, sbv, ex, mx, mn;
      logic cf, ofl;
      m   = (64'd1 << w) - 1;
      ua  = {32'd0, x} & m;
      ub  = {32'd0, y} & m;
      mx  = (64'sd1 <<< (w - 1)) - 1;
      mn  = -(64'sd1 <<< (w - 1));
      sa  = (longint'(ua) > mx) ? longint'(ua) - (64'sd1 <<< w) : longint'(ua);
      sbv = (longint'(ub) > mx) ? longint'(ub) - (64'sd1 <<< w) : longint'(ub);
      if (s) begin
         res = ua - ub; ex = sa - sbv; cf = (ua >= ub);
      end else begin
         res = ua + ub; ex = sa + sbv; cf = ((res >> w) & 64'd1) != 0;
      end
      ofl = (ex > mx) || (ex < mn);
      if (SAT && ofl) res = (ex > 0) ? longint'(mx) : longint'(mn);
      return {ofl, cf, 32'(res & m)};
   endfunction

   function automatic logic [31:0] rnd();
      case ($urandom % 10)
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h0000_007F;
         5: return 32'h0000_0080;
         default: return $urandom;
      endcase
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 2) ? 8 : 32;
      localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
      logic [W-1:0] c_w;
      logic [33:0]  q[$];
      logic [33:0]  held;
      logic         stall_q = 1'b0;

      adder_pipe #(.WIDTH(W), .LATENCY(L)) u_dut (
         .aclk      (aclk),
         .arstn     (arstn),
         .srst      (srst),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .a         (av[g][W-1:0]),
         .b         (bv[g][W-1:0]),
         .sub       (sb[g]),
         .out_valid (ov[g]),
         .out_ready (orr[g]),
         .c         (c_w),
         .carry     (cy[g]),
         .ovf       (of[g])
      );
      assign cv[g] = 32'(c_w);

      always @(negedge aclk) begin
         if (!arstn || srst) begin
            q.delete();
            stall_q = 1'b0;
         end else begin
            if (ov[g] && stall_q)
               check($sformatf("stable_dut%0d", g), {of[g], cy[g], cv[g]}, held);
            if (ov[g] && orr[g]) begin
               if (q.size() == 0) begin
                  chk++; err++;
                  $display("FAIL spurious_dut%0d got output %h with nothing expected", g, cv[g]);
               end else
                  check($sformatf("result_dut%0d", g), {of[g], cy[g], cv[g]}, q.pop_front());
            end
            if (iv[g] && ir[g]) q.push_back(model(W, av[g], bv[g], sb[g]));
            stall_q = ov[g] && !orr[g];
            held    = {of[g], cy[g], cv[g]};
         end
      end
   end

   task automatic single(int g, int lat, logic [31:0] x, logic [31:0] y, logic s, logic [33:0] e);
      int n;
      iv[g] = 1'b1; av[g] = x; bv[g] = y; sb[g] = s;
      @(posedge aclk); #1;
      iv[g] = 1'b0;
      n = 1;
      while (!ov[g] && n < 40) begin @(posedge aclk); #1; n++; end
      check($sformatf("latency_dut%0d", g), 34'(n), 34'(lat));
      check($sformatf("directed_dut%0d", g), {of[g], cy[g], cv[g]}, e);
      @(posedge aclk); #1;
   endtask

   task automatic push(int g, logic [31:0] x, logic [31:0] y, logic s);
      int n;
      logic acc;
      n = 0;
      iv[g] = 1'b1; av[g] = x; bv[g] = y; sb[g] = s;
      do begin
         @(negedge aclk); acc = ir[g];
         @(posedge aclk); #1; n++;
      end while (!acc && n < 50);
      iv[g] = 1'b0;
      check("push_accept", 34'(acc), 34'd1);
   endtask

   task automatic expect_empty(string name);
      int bad;
      bad = 0;
      for (int g = 0; g < 3; g++) orr[g] = 1'b1;
      repeat (10) begin
         @(negedge aclk);
         if (ov[0] || ov[1]) bad++;
      end
      @(posedge aclk); #1;
      check(name, 34'(bad), 34'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int acc, pop, cyc, drop, hold, notrdy;
      logic take;
      arstn = 1'b0; srst = 1'b0;
      for (int g = 0; g < 3; g++) begin
         iv[g] = 1'b0; orr[g] = 1'b1; sb[g] = 1'b0; av[g] = '0; bv[g] = '0;
      end
      repeat (2) @(negedge aclk);
      for (int g = 0; g < 3; g++)
         check($sformatf("reset_dut%0d", g), {ov[g], of[g], cy[g], cv[g]}, 34'd0);
      @(posedge aclk); #1;
      arstn = 1'b1;
      @(posedge aclk); #1;

      // Directed cases with exact expected values
      single(0, 4, 32'h0000_FFFF, 32'h1, 1'b0, {1'b0, 1'b0, 32'h0001_0000});
      single(0, 4, 32'h7FFF_FFFF, 32'h1, 1'b0,
             {1'b1, 1'b0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000});
      single(0, 4, 32'd5, 32'd7, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
      single(0, 4, 32'd7, 32'd5, 1'b1, {1'b0, 1'b1, 32'd2});
      single(1, 1, 32'hFFFF_FFFF, 32'h1, 1'b0, {1'b0, 1'b1, 32'h0});
      single(2, 8, 32'h0F, 32'h01, 1'b0, {1'b0, 1'b0, 32'h10});
      single(2, 8, 32'h80, 32'h01, 1'b1, {1'b1, 1'b1, SAT ? 32'h80 : 32'h7F});

      // Eight back-to-back items with output stalled in cycles 3..9
      acc = 0; pop = 0; cyc = 0; drop = -1; hold = -1;
      av[0] = $urandom; bv[0] = $urandom; sb[0] = 1'($urandom);
      while (pop < 8 && cyc < 60) begin
         orr[0] = !(cyc >= 3 && cyc <= 9);
         iv[0]  = (acc < 8);
         @(negedge aclk);
         take = iv[0] && ir[0];
         if (iv[0] && !ir[0] && drop < 0) begin drop = cyc; hold = acc - pop; end
         if (ov[0] && orr[0]) pop++;
         if (take) acc++;
         @(posedge aclk); #1;
         cyc++;
         if (take) begin av[0] = $urandom; bv[0] = $urandom; sb[0] = 1'($urandom); end
      end
      iv[0] = 1'b0; orr[0] = 1'b1;
      check("stream_drop_cycle", 34'(drop), 34'd4);
      check("stream_held", 34'(hold), 34'd4);
      check("stream_pops", 34'(pop), 34'd8);

      // Synchronous flush, with a same-cycle input on the 1-stage build
      orr[0] = 1'b0;
      repeat (4) push(0, rnd(), rnd(), 1'($urandom));
      @(negedge aclk);
      check("full_in_ready", 34'(ir[0]), 34'd0);
      @(posedge aclk); #1;
      srst = 1'b1; iv[1] = 1'b1; av[1] = 32'h1234; bv[1] = 32'h1;
      @(posedge aclk); #1;
      srst = 1'b0; iv[1] = 1'b0;
      check("srst_flush", {ov[0], of[0], cy[0], cv[0]}, 34'd0);
      check("srst_drop", 34'(ov[1]), 34'd0);
      expect_empty("srst_empty");

      // Asynchronous reset in mid-cycle with a full pipeline
      orr[0] = 1'b0;
      repeat (4) push(0, rnd(), rnd(), 1'($urandom));
      @(posedge aclk); #3;
      arstn = 1'b0;
      #1;
      check("arst_async", {ov[0], of[0], cy[0], cv[0]}, 34'd0);
      @(posedge aclk); #3;
      arstn = 1'b1;
      @(posedge aclk); #1;
      expect_empty("arst_empty");

      // Full-rate random sweep on all builds
      notrdy = 0;
      repeat (1000) begin
         for (int g = 0; g < 3; g++) begin
            iv[g] = 1'b1; orr[g] = 1'b1; av[g] = rnd(); bv[g] = rnd(); sb[g] = 1'($urandom);
         end
         @(negedge aclk);
         for (int g = 0; g < 3; g++) if (!ir[g]) notrdy++;
         @(posedge aclk); #1;
      end
      check("throughput", 34'(notrdy), 34'd0);

      // Random valid and backpressure
      repeat (400) begin
         for (int g = 0; g < 3; g++) begin
            iv[g] = ($urandom % 4) != 0; orr[g] = ($urandom % 3) != 0;
            av[g] = rnd(); bv[g] = rnd(); sb[g] = 1'($urandom);
         end
         @(posedge aclk); #1;
      end
      for (int g = 0; g < 3; g++) begin iv[g] = 1'b0; orr[g] = 1'b1; end
      repeat (20) @(posedge aclk);
      #1;
      check("drain_dut0", 34'(g_dut[0].q.size()), 34'd0);
      check("drain_dut1", 34'(g_dut[1].q.size()), 34'd0);
      check("drain_dut2", 34'(g_dut[2].q.size()), 34'd0);

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
